// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and default constants for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int BUS_DATA_W    = 12;
  localparam int BUS_NUM_SRC   = 4;
  localparam int BUS_IDLE_WORD = 0;

  // Owner index width; a single source still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// Request, lock, data and registered bus signals shared by sources and arbiter.
interface shared_bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC = BUS_NUM_SRC,
  parameter int DATA_W  = BUS_DATA_W
);

  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC-1:0]        lock;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        grant;
  logic [idx_w(NUM_SRC)-1:0] bus_owner;
  logic                      bus_valid;
  logic [DATA_W-1:0]         bus_out;

  // Sources drive requests and data, and see the registered bus.
  modport master (
    output req, lock, src_data,
    input  grant, bus_owner, bus_valid, bus_out
  );

  // The arbiter consumes requests and drives the registered bus.
  modport slave (
    input  req, lock, src_data,
    output grant, bus_owner, bus_valid, bus_out
  );

endinterface

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC = BUS_NUM_SRC,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_SRC-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  // Two copies of req side by side let the scan run straight past the wrap.
  logic [2*NUM_SRC-1:0] dbl;

  assign dbl     = {req, req};
  assign any_req = |req;

  // Scan last+1 .. last+NUM_SRC and keep the first hit.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    logic found;
    int   pos;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!found && dbl[int'(last) + i]) begin
        found = 1'b1;
        pos   = int'(last) + i;
        if (pos >= NUM_SRC) pos = pos - NUM_SRC;
        onehot[pos] = 1'b1;
        idx         = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Registered shared-bus multiplexer with round-robin arbitration and capped locked bursts.
module shared_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC   = BUS_NUM_SRC,
  parameter int DATA_W    = BUS_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_bus_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [DATA_W-1:0] IDLE_WORD = DATA_W'(BUS_IDLE_WORD);

  arb_state_t         state, state_nxt;
  logic [NUM_SRC-1:0] grant, grant_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic               valid, valid_nxt;
  logic [DATA_W-1:0]  out_q, out_nxt;
  logic [CNT_W-1:0]   burst_cnt, cnt_nxt;
  logic [IDX_W-1:0]   last, last_nxt;

  logic [NUM_SRC-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic [DATA_W-1:0]  own_word, win_word;
  logic               hold;

  rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .req     (bus.req),
    .last    (last),
    .onehot  (win_onehot),
    .idx     (win_idx),
    .any_req (any_req)
  );

  // One-hot data muxes for the current owner and the arbitration winner.
  always_comb begin
    own_word = '0;
    win_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i])      own_word = own_word | bus.src_data[i*DATA_W +: DATA_W];
      if (win_onehot[i]) win_word = win_word | bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  // Owner keeps the bus only while requesting, locked and under the beat cap.
  assign hold = (|(grant & bus.req & bus.lock)) && (int'(burst_cnt) < MAX_BURST - 1);

  // Next-state, grant, data and pointer decisions.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = owner;
    valid_nxt = valid;
    out_nxt   = out_q;
    cnt_nxt   = burst_cnt;
    last_nxt  = last;
    if (state == BUSY && hold) begin
      out_nxt = own_word;
      cnt_nxt = burst_cnt + CNT_W'(1);
    end else if (any_req) begin
      state_nxt = BUSY;
      grant_nxt = win_onehot;
      owner_nxt = win_idx;
      valid_nxt = 1'b1;
      out_nxt   = win_word;
      cnt_nxt   = '0;
      last_nxt  = win_idx;
    end else begin
      state_nxt = IDLE;
      grant_nxt = '0;
      valid_nxt = 1'b0;
      out_nxt   = IDLE_WORD;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      valid     <= 1'b0;
      out_q     <= IDLE_WORD;
      burst_cnt <= '0;
      last      <= IDX_W'(NUM_SRC - 1);
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      owner     <= owner_nxt;
      valid     <= valid_nxt;
      out_q     <= out_nxt;
      burst_cnt <= cnt_nxt;
      last      <= last_nxt;
    end
  end

  assign bus.grant     = grant;
  assign bus.bus_owner = owner;
  assign bus.bus_valid = valid;
  assign bus.bus_out   = out_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: main config, NUM_SRC=1 and MAX_BURST=1 variants.
module tb_shared_bus_arbiter;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  shared_bus_arbiter_if #(.NUM_SRC(4), .DATA_W(12)) if_a ();
  shared_bus_arbiter_if #(.NUM_SRC(1), .DATA_W(12)) if_b ();
  shared_bus_arbiter_if #(.NUM_SRC(4), .DATA_W(12)) if_c ();

  shared_bus_arbiter #(.NUM_SRC(4), .DATA_W(12), .MAX_BURST(4)) dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  shared_bus_arbiter #(.NUM_SRC(1), .DATA_W(12), .MAX_BURST(2)) dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );
  shared_bus_arbiter #(.NUM_SRC(4), .DATA_W(12), .MAX_BURST(1)) dut_c (
    .clk (clk), .rst (rst), .bus (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] o,
                         input logic v, input logic [11:0] d);
    check({tag, ".grant"}, 32'(if_a.grant), 32'(g));
    check({tag, ".owner"}, 32'(if_a.bus_owner), 32'(o));
    check({tag, ".valid"}, 32'(if_a.bus_valid), 32'(v));
    check({tag, ".out"},   32'(if_a.bus_out), 32'(d));
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    if_a.req = '0; if_a.lock = '0; if_a.src_data = '0;
    if_b.req = '0; if_b.lock = '0; if_b.src_data = '0;
    if_c.req = '0; if_c.lock = '0; if_c.src_data = '0;
    #2  rst = 1'b1;
    #10 rst = 1'b0;
    #1;
    // 1. Reset state, then a single-cycle request from source 2.
    check_a("reset", 4'b0000, 2'd0, 1'b0, 12'h000);
    check("reset.b_grant", 32'(if_b.grant), 32'd0);
    if_a.req = 4'b0100;
    if_a.src_data[2*12 +: 12] = 12'hA5C;
    tick();
    check_a("first", 4'b0100, 2'd2, 1'b1, 12'hA5C);
    if_a.req = 4'b0000;
    tick();
    check_a("idle", 4'b0000, 2'd2, 1'b0, 12'h000);

    // 2. Fair rotation with all sources requesting.
    pulse_reset();
    if_a.src_data = {12'h103, 12'h102, 12'h101, 12'h100};
    if_a.req = 4'b1111;
    tick(); check_a("rot0", 4'b0001, 2'd0, 1'b1, 12'h100);
    tick(); check_a("rot1", 4'b0010, 2'd1, 1'b1, 12'h101);
    tick(); check_a("rot2", 4'b0100, 2'd2, 1'b1, 12'h102);
    tick(); check_a("rot3", 4'b1000, 2'd3, 1'b1, 12'h103);
    tick(); check_a("rot4", 4'b0001, 2'd0, 1'b1, 12'h100);

    // 3. Locked burst on source 1 capped at 4 beats, with changing data.
    if_a.req = 4'b0000;
    pulse_reset();
    if_a.src_data[3*12 +: 12] = 12'h3C3;
    if_a.req  = 4'b1010;
    if_a.lock = 4'b0010;
    for (int t = 0; t < 4; t++) begin
      if_a.src_data[1*12 +: 12] = 12'h1B0 + 12'(t);
      tick();
      check_a($sformatf("burst%0d", t), 4'b0010, 2'd1, 1'b1, 12'h1B0 + 12'(t));
    end
    if_a.src_data[1*12 +: 12] = 12'h1B4;
    tick(); check_a("burst_src3", 4'b1000, 2'd3, 1'b1, 12'h3C3);
    tick(); check_a("burst_back1", 4'b0010, 2'd1, 1'b1, 12'h1B4);

    // 4. Owner drops its request during its second beat.
    if_a.src_data[1*12 +: 12] = 12'h1B5;
    tick(); check_a("drop_beat2", 4'b0010, 2'd1, 1'b1, 12'h1B5);
    if_a.src_data[0*12 +: 12] = 12'h0A0;
    if_a.req = 4'b0001;
    tick(); check_a("drop_next", 4'b0001, 2'd0, 1'b1, 12'h0A0);

    // 5. Asynchronous reset in the middle of a locked burst.
    if_a.lock = 4'b0001;
    tick(); check_a("pre_rst", 4'b0001, 2'd0, 1'b1, 12'h0A0);
    #1 rst = 1'b1;
    #1 check_a("async_rst", 4'b0000, 2'd0, 1'b0, 12'h000);
    if_a.req  = 4'b1111;
    if_a.lock = 4'b0000;
    #1 rst = 1'b0;
    tick(); check_a("post_rst", 4'b0001, 2'd0, 1'b1, 12'h0A0);
    if_a.req = 4'b0000;

    // 6. Degenerate configurations: single source, and locking disabled.
    if_b.src_data = 12'h777;
    if_b.req  = 1'b1;
    if_b.lock = 1'b1;
    if_c.src_data = {12'h333, 12'h222, 12'h111, 12'h000};
    if_c.req  = 4'b0011;
    if_c.lock = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("b_grant%0d", k), 32'(if_b.grant), 32'd1);
      check($sformatf("b_out%0d", k), 32'(if_b.bus_out), 32'h777);
      check($sformatf("b_cnt%0d", k), 32'(dut_b.burst_cnt), 32'(k % 2));
      check($sformatf("c_grant%0d", k), 32'(if_c.grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("c_out%0d", k), 32'(if_c.bus_out), (k % 2 == 0) ? 32'h000 : 32'h111);
    end
    if_b.req = 1'b0;
    tick();
    check("b_drop_grant", 32'(if_b.grant), 32'd0);
    check("b_drop_valid", 32'(if_b.bus_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Parametrised, registered bus multiplexer with built-in round-robin arbitration. It replaces fixed, externally selected bus sourcing when several agents, such as core register files or data-memory ports, contend for one shared data bus in the multicore processor. Requesters raise `req`; the block grants one owner per cycle, registers that owner's word onto the bus, and supports locked bursts with a bounded tenure so that no source starves.

## Interface
Parameters:
- `NUM_SRC`, 4: number of bus sources; legal range is 1 to 16.
- `DATA_W`, 12: bus word width.
- `MAX_BURST`, 4: maximum consecutive beats in one locked tenure; must be ≥1. `MAX_BURST`=1 disables locking.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock; all state changes on its rising edge.
  - `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_SRC  per-source bus request, level-sensitive.
- `lock`  in  NUM_SRC  per-source burst hold; honoured only for the current owner while its `req` is high.
- `src_data`  in  NUM_SRC*DATA_W  flattened source words; source i occupies bits [i*DATA_W +: DATA_W].
- `grant`  out  NUM_SRC  registered one-hot grant; all zeros when idle.
- `bus_owner`  out  max(1,$clog2(NUM_SRC))  registered index of the current owner.
- `bus_valid`  out  1  high while `bus_out` carries a granted word.
- `bus_out`  out  DATA_W  registered bus word; 0 when idle.

## Operation
- **State machine states:** IDLE and BUSY.
- **Round-robin pointer `last`:** reset to NUM_SRC-1, so the first search starts at source 0.
- **Winner selection:** the winner is the first requesting index found scanning `last`+1, `last`+2, … mod NUM_SRC.
- **IDLE:**
  - If any `req` is high, go to BUSY. On the same edge, load `grant`, `bus_owner` and `bus_out` from the winner's `src_data`, set `bus_valid`=1, set `burst_cnt`=0 and set `last`=winner.
  - Otherwise stay in IDLE with `grant`=0, `bus_valid`=0 and `bus_out`=0.
- **BUSY, owner continues:** applies when the owner has `req` && `lock` && `burst_cnt` < MAX_BURST-1.
  - The owner keeps the grant.
  - `bus_out` reloads from the owner's current `src_data`.
  - `burst_cnt` increments.
- **BUSY, tenure ends:** applies in every other case. Re-arbitrate from `last`+1 with no idle bubble.
  - The previous owner has lowest priority. If it is the only requester, it wins again and `burst_cnt` restarts at 0.
  - If no `req` is high, go to IDLE and drive `bus_out`=0 and `bus_valid`=0.
- **Lock rules:**
  - `lock` on a non-owner is ignored.
  - `lock` without `req` is ignored.
- **Owner drops `req`:** the tenure ends at the next edge even when `lock` is high.
- **Sampling:** `src_data` changes on non-owned sources never affect `bus_out`.
- **Width:** `burst_cnt` is $clog2(MAX_BURST+1) bits wide and never wraps, because it is cleared on every new tenure.
- **NUM_SRC=1:** `grant` is simply `req` delayed by one cycle, and the burst cap still applies as re-grant to the same source.

## Timing
- **Latency:** `req` sampled high at edge n means `grant`, `bus_owner`, `bus_valid` and `bus_out` are valid after edge n. The result is one cycle of latency, with the data captured on that same edge.
- **Back-to-back tenures:** `bus_valid` stays high continuously while any `req` is high.
- **Reset values (all asynchronous):** `grant`=0, `bus_owner`=0, `bus_valid`=0, `bus_out`=0, state=IDLE, `burst_cnt`=0, `last`=NUM_SRC-1.
- **Reset mid-tenure:** all outputs clear immediately, without waiting for a clock edge. After `rst` deasserts, the first grant follows the priority order from source 0.
- **Outputs:** all outputs are flops; there is no combinational path from inputs to outputs.

## Structure
- **Package `bus_arb_pkg`:**
  - state enum `arb_state_t` with values IDLE and BUSY;
  - default-width constants `BUS_DATA_W`=12 and `BUS_NUM_SRC`=4;
  - the idle bus value constant `BUS_IDLE_WORD`=0.
- **Sub-module `rr_pick`:** a combinational round-robin picker.
  - Inputs: `req` and `last`.
  - Outputs: the one-hot winner, the winner index and `any_req`.
  - It is implemented as a double-width priority scan.
- **Top level:** holds the FSM, burst counter, pointer and registered data mux.

## Test plan
1. **Reset and first grant:** after reset, check all outputs are 0. Then assert `req`=4'b0100 with `src_data[2]`=12'hA5C for one cycle. Expect `grant`=4'b0100, `bus_owner`=2, `bus_out`=12'hA5C and `bus_valid`=1 after the next edge, then IDLE with `bus_out`=0.
2. **Fair rotation:** hold `req`=4'b1111 with no lock. Expect grants to rotate 0,1,2,3,0 on consecutive cycles, with `bus_valid` never dropping.
3. **Burst cap:** set MAX_BURST=4, hold `req`=4'b1010 and `lock`=4'b0010, with source 1 first. Expect source 1 to own 4 beats with `bus_out` tracking changing `src_data[1]`, then source 3 for 1 beat, then source 1 again.
4. **Owner drops request:** source 1 is locked. Drop `req[1]` during its second beat while `req[0]`=1. Expect `grant`=4'b0001 at the next edge.
5. **Asynchronous reset:** assert `rst` mid-burst between clock edges. Expect all outputs 0 before the next edge. After release with `req`=4'b1111, expect the first grant to source 0.
6. **Degenerate parameters:**
   - Set NUM_SRC=1 with `req` held and `lock` held, and MAX_BURST=2. Expect continuous grants with `burst_cnt` restarting every 2 beats.
   - Set MAX_BURST=1 with `lock` high. Expect `lock` to be ignored.
